lbist_ctrl: RTL and testbench

LBIST session controller for the 8-bit pattern generator (`lfsr_dd`: taps 7/5/4/3, seeds to 8'hFF on its synchronous reset).
- Runs one self-test on a `start` pulse: holds the generator in reset to seed it, then releases it for a fixed number of patterns.
- Compresses the circuit-under-test (CUT) response into an 8-bit MISR and compares the final signature to a golden value.
- Sits between the test-access logic (start/done/pass) and the generator/CUT pair.

---
 rtl/lbist_pkg.sv | 22 ++
 rtl/lbist_misr8.sv | 18 +
 rtl/lbist_ctrl.sv | 86 ++++++++
 tb/tb_lbist_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: session states, MISR/LFSR tap mask, seed values
// and the single-step MISR compression function.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    RUN,
    COMPARE,
    DONE
  } state_t;

  // Feedback taps at bits 7,5,4,3, shared by the pattern generator and the MISR
  localparam logic [7:0] TAP_MASK  = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'hFF;
  localparam logic [7:0] MISR_SEED = 8'h00;

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] d);
    return {m[6:0], ^(m & TAP_MASK)} ^ d;
  endfunction

endpackage

// File: rtl/lbist_misr8.sv
// 8-bit multiple-input signature register; clr reseeds, en folds in one response.
module misr8
  import lbist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) q <= MISR_SEED;
    else if (en)      q <= misr_step(q, d);
  end

endmodule

// File: rtl/lbist_ctrl.sv
// LBIST session controller: seeds the generator, runs PAT_CNT patterns into a MISR,
// compares against GOLDEN_SIG. Define LBIST_CTRL_SIG_OUT_EN to expose the MISR as signature.
module lbist_ctrl
  import lbist_pkg::*;
#(
  parameter int unsigned PAT_CNT    = 255,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cut_resp,
  output logic       lfsr_rst,
  output logic       busy,
  output logic       done,
  output logic       pass
`ifdef LBIST_CTRL_SIG_OUT_EN
  , output logic [7:0] signature
`endif
);

  // Terminal count is PAT_CNT-1 so a 16-bit counter never wraps for PAT_CNT=65535
  localparam logic [15:0] LAST = 16'(PAT_CNT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;
  logic        pass_q;
  logic [7:0]  misr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == SEED)     cnt_q  <= '0;
      else if (state_q == RUN) cnt_q  <= cnt_q + 16'd1;
      if (state_q == COMPARE)  pass_q <= (misr_q == GOLDEN_SIG);
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = SEED;
      SEED: begin
        busy    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        lfsr_rst = 1'b0;
        if (cnt_q == LAST) state_d = COMPARE;
      end
      COMPARE: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = SEED;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pass = pass_q;

  misr8 u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (state_q == SEED),
    .en    (state_q == RUN),
    .d     (cut_resp),
    .q     (misr_q)
  );

`ifdef LBIST_CTRL_SIG_OUT_EN
  assign signature = misr_q;
`endif

endmodule

// File: tb/tb_lbist_ctrl.sv
// Self-checking bench for lbist_ctrl: five configurations against a behavioural session model.
module tb_lbist_ctrl;
  import lbist_pkg::*;

  localparam int N = 5;

  function automatic logic [7:0] mstep(input logic [7:0] m, input logic [7:0] d);
    return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ d;
  endfunction

  function automatic logic [7:0] lfsr_sig(input int n);
    logic [7:0] m, l;
    m = 8'h00;
    l = 8'hFF;
    for (int k = 0; k < n; k++) begin
      m = mstep(m, l);
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return m;
  endfunction

  localparam logic [7:0] G255 = lfsr_sig(255);

  int         pc_v [N] = '{1, 2, 2, 255, 13};
  logic [7:0] gs_v [N] = '{8'hFF, 8'h03, 8'h04, G255, 8'h5A};

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [N-1:0] lrst, busy, done, pass;
  logic [7:0] cut [N];
  logic [7:0] gq [N];
  logic [7:0] rnd = 8'h00;

`ifdef LBIST_CTRL_SIG_OUT_EN
  logic [7:0] sig [N];
  `define TB_SIG(i) , .signature(sig[i])
`else
  `define TB_SIG(i)
`endif

  always #5 clk = ~clk;

  lbist_ctrl #(.PAT_CNT(1),   .GOLDEN_SIG(8'hFF)) u0 (.clk(clk), .reset(reset), .start(start),
    .cut_resp(cut[0]), .lfsr_rst(lrst[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]) `TB_SIG(0));
  lbist_ctrl #(.PAT_CNT(2),   .GOLDEN_SIG(8'h03)) u1 (.clk(clk), .reset(reset), .start(start),
    .cut_resp(cut[1]), .lfsr_rst(lrst[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]) `TB_SIG(1));
  lbist_ctrl #(.PAT_CNT(2),   .GOLDEN_SIG(8'h04)) u2 (.clk(clk), .reset(reset), .start(start),
    .cut_resp(cut[2]), .lfsr_rst(lrst[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]) `TB_SIG(2));
  lbist_ctrl #(.PAT_CNT(255), .GOLDEN_SIG(G255))  u3 (.clk(clk), .reset(reset), .start(start),
    .cut_resp(cut[3]), .lfsr_rst(lrst[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]) `TB_SIG(3));
  lbist_ctrl #(.PAT_CNT(13),  .GOLDEN_SIG(8'h5A)) u4 (.clk(clk), .reset(reset), .start(start),
    .cut_resp(cut[4]), .lfsr_rst(lrst[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]) `TB_SIG(4));

  // Pattern generators (one per DUT), reset by each DUT's lfsr_rst like the real parent
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      gq[i] <= lrst[i] ? LFSR_SEED : {gq[i][6:0], gq[i][7] ^ gq[i][5] ^ gq[i][4] ^ gq[i][3]};

  always_comb begin
    cut[0] = 8'hFF;
    cut[1] = 8'h01;
    cut[2] = 8'h01;
    cut[3] = gq[3];
    cut[4] = gq[4] ^ rnd;
  end

  // Session model: t = cycles since the start-sampling edge (-1 when not in a session);
  // responses collected during the PAT_CNT run cycles and folded into the signature.
  int         t     [N] = '{default: -1};
  bit         mdone [N] = '{default: 1'b0};
  bit         mpass [N] = '{default: 1'b0};
  logic [7:0] msig  [N] = '{default: 8'h00};
  logic [7:0] resp  [N][256];
  int         rc    [N] = '{default: 0};

  function automatic logic [7:0] fold(input int i);
    logic [7:0] m = 8'h00;
    for (int k = 0; k < rc[i]; k++) m = mstep(m, resp[i][k]);
    return m;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        t[i] = -1; mdone[i] = 1'b0; mpass[i] = 1'b0; rc[i] = 0; msig[i] = 8'h00;
      end else if (t[i] < 0) begin
        if (start) begin t[i] = 0; mdone[i] = 1'b0; end
      end else if (t[i] == 0) begin
        rc[i] = 0; msig[i] = 8'h00; t[i] = 1;
      end else if (t[i] <= pc_v[i]) begin
        resp[i][rc[i]] = cut[i]; rc[i]++; msig[i] = fold(i); t[i]++;
      end else begin
        mpass[i] = (msig[i] == gs_v[i]); mdone[i] = 1'b1; t[i] = -1;
      end
    end
  end

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(t[i] >= 0));
      chk($sformatf("lfsr_rst%0d", i), 32'(lrst[i]), 32'(!(t[i] >= 1 && t[i] <= pc_v[i])));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(mdone[i]));
      if (mdone[i]) chk($sformatf("pass%0d", i), 32'(pass[i]), 32'(mpass[i]));
`ifdef LBIST_CTRL_SIG_OUT_EN
      chk($sformatf("sig%0d", i), 32'(sig[i]), 32'(msig[i]));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
    rnd = 8'($urandom);
  endtask

  initial begin
    int n, d3;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_lfsr_rst", 32'(lrst[3]), 32'd1);
    chk("rst_busy", 32'(busy[3]), 32'd0);
    chk("rst_done", 32'(done[3]), 32'd0);
    chk("rst_pass", 32'(pass[3]), 32'd0);
    reset = 1'b0;
    tick();

    // First session: literal pins on timing, patterns and results
    start = 1'b1;
    n = 0; d3 = -1;
    while (d3 < 0 && n < 400) begin
      tick();
      n++;
      if (n == 1) begin
        start = 1'b0;
        chk("seed_busy", 32'(busy[3]), 32'd1);
        chk("seed_lfsr_rst", 32'(lrst[3]), 32'd1);
      end
      if (n == 2) begin
        chk("run0_lfsr_rst", 32'(lrst[3]), 32'd0);
        chk("pat0", 32'(cut[3]), 32'hFF);
      end
      if (n == 3) begin
        chk("pat1", 32'(cut[3]), 32'hFE);
        chk("p1_done_early", 32'(done[0]), 32'd0);
      end
      if (n == 4) begin
        chk("pat2", 32'(cut[3]), 32'hFC);
        chk("p1_done_3cyc", 32'(done[0]), 32'd1);
        chk("p1_pass", 32'(pass[0]), 32'd1);
`ifdef LBIST_CTRL_SIG_OUT_EN
        chk("p1_sig", 32'(sig[0]), 32'hFF);
`endif
      end
      if (n == 5) begin
        chk("p2_done", 32'(done[1]), 32'd1);
        chk("p2_pass_g03", 32'(pass[1]), 32'd1);
        chk("p2_pass_g04", 32'(pass[2]), 32'd0);
`ifdef LBIST_CTRL_SIG_OUT_EN
        chk("p2_sig", 32'(sig[1]), 32'h03);
`endif
      end
      if (n == 50) start = 1'b1;  // ignored by the 255-pattern session
      if (n == 51) start = 1'b0;
      if (done[3]) d3 = n;
    end
    chk("latency255", 32'(d3 - 1), 32'd257);
    chk("p255_pass", 32'(pass[3]), 32'd1);
`ifdef LBIST_CTRL_SIG_OUT_EN
    chk("p255_sig", 32'(sig[3]), 32'(G255));
`endif

    // Abort in RUN cycle 10, then rerun undisturbed
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    chk("abort_busy", 32'(busy[3]), 32'd0);
    chk("abort_lfsr_rst", 32'(lrst[3]), 32'd1);
    chk("abort_done", 32'(done[3]), 32'd0);
`ifdef LBIST_CTRL_SIG_OUT_EN
    chk("abort_misr", 32'(sig[3]), 32'h00);
`endif
    reset = 1'b0;
    tick();
    start = 1'b1;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      start = 1'b0;
      if (done[3]) break;
    end
    chk("rerun_latency", 32'(n - 1), 32'd257);
    chk("rerun_pass", 32'(pass[3]), 32'd1);

    // Restart from DONE drops done on the next cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", 32'(done[3]), 32'd0);
    chk("restart_busy", 32'(busy[3]), 32'd1);

    // Randomised traffic: sporadic starts, rare resets, random responses
    repeat (4000) begin
      start = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
